dmem_ctrl: RTL and testbench
============================

// Module: dmem_ctrl
// PURPOSE
//  Parametrised data-memory controller for the multi-cycle CPU datapath; replaces the single-cycle data memory.
//  Byte/half/word loads and stores, sign- or zero-extended loads, misalignment/range fault detection,
//  configurable wait states, valid/ready handshakes on request and response, and sequential clear-on-reset sweep.
// PARAMETERS
//  ADDR_WIDTH   12  word-index bits; DEPTH = 2**ADDR_WIDTH 32-bit words
//  WAIT_CYCLES  1   extra cycles between request accept and response (0..15)
//  TRACE        1   1: $display every committed store as "@%h: *%h <= %h" (pc, byte addr, merged word)
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   controller can accept (high only in IDLE)
//  req_we       in   1   1 store, 0 load
//  req_size     in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned in   1   load zero-extends when 1, sign-extends when 0
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  req_pc       in   32  PC of issuing instruction, trace only
//  rsp_valid    out  1   response present
//  rsp_ready    in   1   consumer accepts response
//  rsp_rdata    out  32  extended load data; 0 for stores and faults
//  rsp_err      out  1   fault: misaligned, out of range, or illegal size
//  init_busy    out  1   clear sweep in progress
// BEHAVIOUR
//  FSM states: INIT, IDLE, WAIT, RESP.
//  Reset: state<=INIT, sweep counter<=0, rsp_valid<=0, rsp_rdata<=0, rsp_err<=0; req_ready=0, init_busy=1.
//  INIT: one word zeroed per cycle, counter 0..DEPTH-1; after writing DEPTH-1 go IDLE (DEPTH cycles total).
//  IDLE: req_ready=1. On req_valid&req_ready, latch all req_* fields; go WAIT if WAIT_CYCLES>0 else RESP.
//  WAIT: count WAIT_CYCLES cycles; on the last one go RESP.
//  Commit edge (entry to RESP):
//   store writes memory, load captures rsp_rdata, rsp_valid<=1, rsp_err set.
//  RESP: rsp_valid, rsp_rdata, rsp_err held stable until rsp_valid&rsp_ready; then IDLE, rsp_valid<=0.
//   Next request accepted no earlier than the following cycle. Minimum accept-to-rsp_valid latency is WAIT_CYCLES+1.
//  Word index = addr[ADDR_WIDTH+1:2]. Fault if size==11, half with addr[0]=1, word with addr[1:0]!=0,
//   or addr[31:ADDR_WIDTH+2]!=0.
//  On fault: memory unchanged, no trace, rsp_rdata=0, rsp_err=1.
//  Store byte: lane addr[1:0] gets wdata[7:0]. Store half: lane addr[1] gets wdata[15:0]. Other bytes preserved.
//  Load: byte/half selected by the same lanes, extended per req_unsigned. Word loads ignore req_unsigned.
//  Reset mid-operation (WAIT or RESP): pending store is dropped if not yet committed; a committed store is wiped
//   by the sweep. rsp_valid drops the cycle after reset.
//  req_valid outside IDLE is ignored; requester must hold the request until accepted.
//  Memory contents are undefined to readers only during INIT, and no reads are possible then.
// STRUCTURE
//  Package dmem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, fault-check function.
//  Sub-module dmem_lane_align (combinational):
//   - store: old word + wdata + size + addr[1:0] -> merged word
//   - load: word + size + addr[1:0] + unsigned -> extended data
//  FSM, counters and storage array stay in dmem_ctrl.
// TESTING
//  After reset, init_busy=1 and req_ready=0 for exactly DEPTH cycles; then word load of 0x0 -> rdata 0, err 0.
//  sw 0x8badf00d @0x10, then lb @0x13 signed -> 0xffffff8b. lbu @0x12 -> 0x000000ad. lh @0x10 -> 0xfffff00d.
//  sb 0x5a @0x11 onto 0x8badf00d -> word 0x8bad5a0d, trace "@<pc>: *00000011 <= 8bad5a0d".
//  sh @0x11, then lw @0x6 -> rsp_err=1; memory unchanged; rdata 0. Store to 0x00004000 with ADDR_WIDTH=12 -> err=1.
//  WAIT_CYCLES=3: accept at cycle t -> rsp_valid at t+4. Hold rsp_ready=0 for 5 cycles -> outputs stable, req_ready=0.
//  Assert reset while in WAIT on a store -> rsp_valid 0 next cycle, INIT sweep restarts, target word reads 0 afterwards.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access-size encodings,
// controller states and the address fault check.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Any address bit above the implemented word range makes the access fault.
  function automatic logic access_fault(input logic [1:0] size,
                                        input logic [31:0] addr,
                                        input int unsigned addr_width);
    logic misaligned;
    logic out_of_range;
    misaligned   = ((size == SZ_HALF) && addr[0]) ||
                   ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    out_of_range = (addr >> (addr_width + 2)) != 32'd0;
    return (size == SZ_ILL) || misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: merges store data into an existing word and extracts
// extended load data from a word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  byte_off,
  input  logic        is_unsigned,
  output logic [31:0] merged_word,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    merged_word = old_word;
    case (size)
      SZ_BYTE: merged_word[{byte_off, 3'b000} +: 8]        = wdata[7:0];
      SZ_HALF: merged_word[{byte_off[1], 4'b0000} +: 16]   = wdata[15:0];
      default: merged_word = wdata;
    endcase
  end

  // Word loads pass straight through, so is_unsigned only matters for sub-word sizes.
  always_comb begin
    sel_byte  = old_word[{byte_off, 3'b000} +: 8];
    sel_half  = old_word[{byte_off[1], 4'b0000} +: 16];
    load_data = old_word;
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
      SZ_HALF: load_data = {{16{~is_unsigned & sel_half[15]}}, sel_half};
      default: load_data = old_word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller: clear sweep after reset, one request at a
// time with configurable wait states, and a held response until it is accepted.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 1,
  parameter bit TRACE       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = '1;
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] sweep_cnt;
  logic [3:0]            wait_cnt;
  logic [31:0]           mem [DEPTH];

  logic        lat_we, lat_unsigned;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr, lat_wdata, lat_pc;

  logic        op_we, op_unsigned, fault, accept, commit;
  logic [1:0]  op_size;
  logic [31:0] op_addr, op_wdata, op_pc;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0] cur_word, merged_word, load_word;

  // With zero wait states the commit happens on the accept edge, so the live
  // request is used while still in IDLE and the latched copy afterwards.
  assign op_we       = (state == IDLE) ? req_we       : lat_we;
  assign op_size     = (state == IDLE) ? req_size     : lat_size;
  assign op_unsigned = (state == IDLE) ? req_unsigned : lat_unsigned;
  assign op_addr     = (state == IDLE) ? req_addr     : lat_addr;
  assign op_wdata    = (state == IDLE) ? req_wdata    : lat_wdata;
  assign op_pc       = (state == IDLE) ? req_pc       : lat_pc;

  assign accept   = req_valid & req_ready;
  assign commit   = (state_next == RESP) && (state != RESP);
  assign fault    = access_fault(op_size, op_addr, ADDR_WIDTH);
  assign word_idx = op_addr[ADDR_WIDTH+1:2];
  assign cur_word = mem[word_idx];

  dmem_lane_align u_align (
    .old_word    (cur_word),
    .wdata       (op_wdata),
    .size        (op_size),
    .byte_off    (op_addr[1:0]),
    .is_unsigned (op_unsigned),
    .merged_word (merged_word),
    .load_data   (load_word)
  );

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    init_busy  = 1'b0;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        if (sweep_cnt == LAST_WORD) state_next = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
      end
      WAIT:    if (wait_cnt == WAIT_LAST) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      sweep_cnt <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == INIT) sweep_cnt <= sweep_cnt + 1'b1;
      wait_cnt <= (state == WAIT) ? wait_cnt + 4'd1 : 4'd0;
      if (commit) begin
        rsp_valid <= 1'b1;
        rsp_err   <= fault;
        rsp_rdata <= (op_we || fault) ? 32'd0 : load_word;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we       <= req_we;
      lat_size     <= req_size;
      lat_unsigned <= req_unsigned;
      lat_addr     <= req_addr;
      lat_wdata    <= req_wdata;
      lat_pc       <= req_pc;
    end
  end

  // Single write port shared by the clear sweep and committed stores.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) mem[sweep_cnt] <= '0;
      else if (commit && op_we && !fault) mem[word_idx] <= merged_word;
    end
  end

`ifndef SYNTHESIS
  if (TRACE) begin : g_trace
    always @(posedge clk) begin
      if (!reset && commit && op_we && !fault)
        $display("@%h: *%h <= %h", op_pc, op_addr, merged_word);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: expected responses are queued when a request
// is issued and compared when the response handshake completes.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;
  localparam int WAITC = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        rsp_valid, rsp_ready, rsp_err, init_busy;
  logic [31:0] rsp_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  exp_t        sb[$];
  logic [7:0]  mbytes [int];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cyc, rsp_cyc;
  logic [31:0] obs_rd;
  logic        obs_err, obs_ok;

  dmem_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WAITC), .TRACE(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_pc       (req_pc),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .init_busy    (init_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte-addressed reference memory; absent bytes read as zero after the sweep.
  task automatic model_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic err);
    int n;
    logic [31:0] v;
    err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
          (size == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'(4 * DEPTH));
    rd = 32'd0;
    v  = 32'd0;
    if (err) return;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) begin
      if (we) mbytes[int'(addr) + i] = wdata[8*i +: 8];
      else if (mbytes.exists(int'(addr) + i)) v[8*i +: 8] = mbytes[int'(addr) + i];
    end
    if (!we) begin
      if (n == 1)      rd = uns ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      else if (n == 2) rd = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      else             rd = v;
    end
  endtask

  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_pc = 32'h1000 + addr;
    req_valid = 1'b1;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("[TB] FAIL accept_timeout: req_ready=%b, required 1", req_ready);
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic collect();
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    obs_ok = rsp_valid; obs_rd = rsp_rdata; obs_err = rsp_err; rsp_cyc = cyc;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic txn(input vec_t v);
    logic [31:0] d;
    logic e;
    model_op(v.we, v.size, v.uns, v.addr, v.wdata, d, e);
    sb.push_back('{v.rd, v.err});
    send(v.we, v.size, v.uns, v.addr, v.wdata);
    collect();
  endtask

  task automatic count_init(output int busy_cycles);
    busy_cycles = 0;
    while (init_busy && !req_ready && busy_cycles < DEPTH + 50) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int busy;
    vec_t v;
    exp_t e;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || init_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_state: rsp_valid=%b req_ready=%b init_busy=%b, required 0 0 1",
               rsp_valid, req_ready, init_busy);
    end
    @(negedge clk);
    reset = 1'b0;
    count_init(busy);
    checks++;
    if (busy != DEPTH || req_ready !== 1'b1 || init_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL init_length: busy cycles=%0d req_ready=%b, required %0d and 1",
               busy, req_ready, DEPTH);
    end
    v = '{"lw_after_init", 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0};
    txn(v);
    e = sb.pop_front();
    checks++;
    if (!obs_ok || obs_rd !== e.rdata || obs_err !== e.err) begin
      errors++;
      $display("[TB] FAIL %s: rdata=%h err=%b, required %h %b", v.name, obs_rd, obs_err, e.rdata, e.err);
    end
  endtask

  task automatic test_load_extend();
    vec_t vs[$];
    exp_t e;
    vs.push_back('{"sw_8badf00d", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h8badf00d, 32'h0, 1'b0});
    vs.push_back('{"lb_13",       1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 32'hffffff8b, 1'b0});
    vs.push_back('{"lbu_12",      1'b0, SZ_BYTE, 1'b1, 32'h12, 32'h0, 32'h000000ad, 1'b0});
    vs.push_back('{"lh_10",       1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, 32'hfffff00d, 1'b0});
    vs.push_back('{"lhu_10",      1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 32'h0000f00d, 1'b0});
    vs.push_back('{"lw_10_uns",   1'b0, SZ_WORD, 1'b1, 32'h10, 32'h0, 32'h8badf00d, 1'b0});
    foreach (vs[i]) begin
      txn(vs[i]);
      e = sb.pop_front();
      checks++;
      if (!obs_ok || obs_rd !== e.rdata || obs_err !== e.err) begin
        errors++;
        $display("[TB] FAIL %s: rdata=%h err=%b, required %h %b", vs[i].name, obs_rd, obs_err, e.rdata, e.err);
      end
      checks++;
      if (rsp_cyc - acc_cyc != WAITC + 1) begin
        errors++;
        $display("[TB] FAIL latency_%s: %0d cycles, required %0d", vs[i].name, rsp_cyc - acc_cyc, WAITC + 1);
      end
    end
  endtask

  task automatic test_store_merge();
    vec_t vs[$];
    exp_t e;
    vs.push_back('{"sb_5a_11",  1'b1, SZ_BYTE, 1'b0, 32'h11, 32'hffffff5a, 32'h0, 1'b0});
    vs.push_back('{"lw_sb",     1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h8bad5a0d, 1'b0});
    vs.push_back('{"sh_beef_12",1'b1, SZ_HALF, 1'b0, 32'h12, 32'h1234beef, 32'h0, 1'b0});
    vs.push_back('{"lw_sh",     1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hbeef5a0d, 1'b0});
    foreach (vs[i]) begin
      txn(vs[i]);
      e = sb.pop_front();
      checks++;
      if (!obs_ok || obs_rd !== e.rdata || obs_err !== e.err) begin
        errors++;
        $display("[TB] FAIL %s: rdata=%h err=%b, required %h %b", vs[i].name, obs_rd, obs_err, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_stall();
    int n = 0;
    exp_t e;
    logic [31:0] d;
    logic er;
    model_op(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, d, er);
    sb.push_back('{32'hbeef5a0d, 1'b0});
    send(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    e = sb.pop_front();
    // A store presented while the response is pending must be ignored.
    req_we = 1'b1; req_size = SZ_WORD; req_addr = 32'h10; req_wdata = 32'h0; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err || req_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold_%0d: valid=%b rdata=%h err=%b req_ready=%b, required 1 %h %b 0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready, e.rdata, e.err);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release: rsp_valid=%b req_ready=%b, required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_faults();
    vec_t vs[$];
    exp_t e;
    vs.push_back('{"sh_misaligned", 1'b1, SZ_HALF, 1'b0, 32'h11, 32'h0000ffff, 32'h0, 1'b1});
    vs.push_back('{"lw_misaligned", 1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1});
    vs.push_back('{"ld_illegal_sz", 1'b0, SZ_ILL,  1'b0, 32'h10, 32'h0, 32'h0, 1'b1});
    vs.push_back('{"sw_range_4000", 1'b1, SZ_WORD, 1'b0, 32'h4000, 32'h11111111, 32'h0, 1'b1});
    vs.push_back('{"lw_range_4000", 1'b0, SZ_WORD, 1'b0, 32'h4000, 32'h0, 32'h0, 1'b1});
    vs.push_back('{"lw_unchanged",  1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hbeef5a0d, 1'b0});
    vs.push_back('{"lw_first_word", 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0});
    vs.push_back('{"sw_last_word",  1'b1, SZ_WORD, 1'b0, 32'h3ffc, 32'hcafe0123, 32'h0, 1'b0});
    vs.push_back('{"lb_last_byte",  1'b0, SZ_BYTE, 1'b0, 32'h3fff, 32'h0, 32'hffffffca, 1'b0});
    foreach (vs[i]) begin
      txn(vs[i]);
      e = sb.pop_front();
      checks++;
      if (!obs_ok || obs_rd !== e.rdata || obs_err !== e.err) begin
        errors++;
        $display("[TB] FAIL %s: rdata=%h err=%b, required %h %b", vs[i].name, obs_rd, obs_err, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_random();
    vec_t v;
    exp_t e;
    for (int i = 0; i < 30; i++) begin
      v.name  = "random";
      v.we    = 1'($urandom_range(0, 1));
      v.size  = 2'($urandom_range(0, 3));
      v.uns   = 1'($urandom_range(0, 1));
      v.addr  = 32'h100 + 32'($urandom_range(0, 15));
      v.wdata = $urandom;
      model_op(v.we, v.size, v.uns, v.addr, v.wdata, v.rd, v.err);
      txn(v);
      e = sb.pop_front();
      checks++;
      if (!obs_ok || obs_rd !== e.rdata || obs_err !== e.err) begin
        errors++;
        $display("[TB] FAIL random_%0d we=%b sz=%0d a=%h: rdata=%h err=%b, required %h %b",
                 i, v.we, v.size, v.addr, obs_rd, obs_err, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_reset_mid();
    int busy;
    vec_t v;
    exp_t e;
    send(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h12345678);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || init_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_state: rsp_valid=%b init_busy=%b, required 0 1", rsp_valid, init_busy);
    end
    reset = 1'b0;
    mbytes.delete();
    count_init(busy);
    checks++;
    if (busy != DEPTH) begin
      errors++;
      $display("[TB] FAIL reset_mid_init: busy cycles=%0d, required %0d", busy, DEPTH);
    end
    v = '{"lw_dropped_store", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0};
    txn(v);
    e = sb.pop_front();
    checks++;
    if (!obs_ok || obs_rd !== e.rdata || obs_err !== e.err) begin
      errors++;
      $display("[TB] FAIL %s: rdata=%h err=%b, required %h %b", v.name, obs_rd, obs_err, e.rdata, e.err);
    end
    v = '{"lw_swept_word", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0};
    txn(v);
    e = sb.pop_front();
    checks++;
    if (!obs_ok || obs_rd !== e.rdata || obs_err !== e.err) begin
      errors++;
      $display("[TB] FAIL %s: rdata=%h err=%b, required %h %b", v.name, obs_rd, obs_err, e.rdata, e.err);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_pc = '0; rsp_ready = 1'b0;
    test_reset();
    test_load_extend();
    test_store_merge();
    test_stall();
    test_faults();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
